uart_tx_arbiter: RTL

Round-robin scheduler that shares one UART_TX serializer between N_REQ byte requesters. It grants one requester at a time and latches that requester's byte and the parity configuration. It then issues a single-cycle Data_Valid to the serializer and holds off further grants until the serializer's busy has risen and fallen. It sits between the protocol/message blocks and the UART_TX instance in the diploma SoC.

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types for the UART TX arbiter: FSM state encoding.
package uart_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set bit of req strictly after
// last_grant wins, wrapping around to index 0 and ending at last_grant itself.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_WD = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_WD-1:0] last_grant,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_WD-1:0] gnt_idx,
  output logic             gnt_any
);

  // Two passes: indices above last_grant first, then the wrapped-around range.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req[i] && (i > int'(last_grant))) begin
        gnt[i]  = 1'b1;
        gnt_idx = ID_WD'(i);
        gnt_any = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_any && req[i] && (i <= int'(last_grant))) begin
        gnt[i]  = 1'b1;
        gnt_idx = ID_WD'(i);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART_TX serializer between N_REQ byte
// requesters. A grant latches the byte and parity config, issues a one-cycle
// Data_Valid, then waits for tx_busy to rise and fall (or times out).
// Build option: define UART_ARB_FIXED_PRIO_EN to give requester 0 absolute
// priority, with the remaining requesters round-robin among themselves.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_WD   = 8,
  parameter int BUSY_WAIT = 4,
  parameter int ID_WD     = $clog2(N_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*DATA_WD-1:0] req_data,
  output logic [N_REQ-1:0]         req_ready,
  input  logic                     cfg_par_en,
  input  logic                     cfg_par_typ,
  output logic [DATA_WD-1:0]       tx_p_data,
  output logic                     tx_data_valid,
  output logic                     tx_par_en,
  output logic                     tx_par_typ,
  input  logic                     tx_busy,
  output logic [ID_WD-1:0]         grant_id,
  output logic                     active,
  output logic                     err_timeout
);

  localparam int                 CNT_W    = $clog2(BUSY_WAIT + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BUSY_WAIT - 1);
  localparam logic [ID_WD-1:0]   LAST_RST = ID_WD'(N_REQ - 1);

  arb_state_t         state;
  arb_state_t         state_nxt;
  logic [ID_WD-1:0]   last_grant;
  logic [CNT_W-1:0]   wait_cnt;

  logic [N_REQ-1:0]   rr_gnt;
  logic [ID_WD-1:0]   rr_idx;
  logic               rr_any;

  logic [N_REQ-1:0]   win_gnt;
  logic [ID_WD-1:0]   win_idx;
  logic               win_any;
  logic               win_upd_last;
  logic [DATA_WD-1:0] win_data;

  logic               grant_now;
  logic               timeout_hit;

`ifdef UART_ARB_FIXED_PRIO_EN
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_WD (ID_WD)
  ) u_rr (
    .req        ({req_valid[N_REQ-1:1], 1'b0}),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // Requester 0 overrides the rotation; its wins leave the rotation pointer
  // alone so the others keep their place in line.
  always_comb begin
    win_gnt      = rr_gnt;
    win_idx      = rr_idx;
    win_any      = rr_any;
    win_upd_last = rr_any;
    if (req_valid[0]) begin
      win_gnt      = '0;
      win_gnt[0]   = 1'b1;
      win_idx      = '0;
      win_any      = 1'b1;
      win_upd_last = 1'b0;
    end
  end
`else
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_WD (ID_WD)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (rr_gnt),
    .gnt_idx    (rr_idx),
    .gnt_any    (rr_any)
  );

  // Plain round-robin across every requester.
  always_comb begin
    win_gnt      = rr_gnt;
    win_idx      = rr_idx;
    win_any      = rr_any;
    win_upd_last = rr_any;
  end
`endif

  // Select the winning requester's byte from the packed bus.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_gnt[i]) begin
        win_data = req_data[i*DATA_WD +: DATA_WD];
      end
    end
  end

  assign grant_now   = (state == IDLE) && win_any;
  assign timeout_hit = (state == WAIT_BUSY) && !tx_busy && (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (win_any) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; req_ready is masked while reset is held so
  // every output reads 0 during reset regardless of req_valid.
  always_comb begin
    req_ready     = '0;
    tx_data_valid = 1'b0;
    active        = 1'b0;
    err_timeout   = 1'b0;
    case (state)
      IDLE:      if (!RST) req_ready = win_gnt;
      ISSUE:     begin
        tx_data_valid = 1'b1;
        active        = 1'b1;
      end
      WAIT_BUSY: begin
        active      = 1'b1;
        err_timeout = timeout_hit;
      end
      WAIT_DONE: active = 1'b1;
      default:   active = 1'b0;
    endcase
  end

  // Frame latch: byte, parity config and owner captured on the grant edge and
  // held until the next grant, so late changes on the inputs cannot leak in.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_p_data  <= '0;
      tx_par_en  <= 1'b0;
      tx_par_typ <= 1'b0;
      grant_id   <= '0;
      last_grant <= LAST_RST;
    end else if (grant_now) begin
      tx_p_data  <= win_data;
      tx_par_en  <= cfg_par_en;
      tx_par_typ <= cfg_par_typ;
      grant_id   <= win_idx;
      if (win_upd_last) begin
        last_grant <= win_idx;
      end
    end
  end

  // Busy-rise wait counter: cleared on issue, counts idle-busy cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if ((state == WAIT_BUSY) && !tx_busy && (wait_cnt != CNT_LAST)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
